logic_pipe_unit: RTL and testbench

LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

---
 rtl/logic_pipe_unit.sv | 109 ++++++++++
 tb/tb_logic_pipe_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit.sv
// rtl/logic_pipe_unit.sv - two-entry bitwise logic pipeline with valid/ready handshakes
// Optional drained-beat counter on OP_CNT when LOGIC_PIPE_UNIT_CNT_EN is defined.
module logic_pipe_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT0,
    output logic             OUT_VALID,
`ifdef LOGIC_PIPE_UNIT_CNT_EN
    input  logic             OUT_READY,
    output logic [15:0]      OP_CNT
`else
    input  logic             OUT_READY
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic             live;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             drain;

    always_comb begin
        result = '0;
        case (OP)
            3'b000:  result = IN0 & IN1;
            3'b001:  result = IN0 | IN1;
            3'b010:  result = ~(IN0 | IN1);
            3'b011:  result = ~(IN0 & IN1);
            3'b100:  result = IN0 ^ IN1;
            3'b101:  result = ~(IN0 ^ IN1);
            3'b110:  result = ~IN0;
            default: result = IN0;
        endcase
    end

    // live holds IN_READY low through reset and until the first edge after release
    assign IN_READY  = live && (state != ST_FULL);
    assign OUT_VALID = (state != ST_EMPTY);
    assign OUT0      = head;
    assign accept    = IN_VALID && IN_READY;
    assign drain     = OUT_VALID && OUT_READY;

    // Vacated slots are cleared so OUT0 reads zero whenever nothing is held
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_EMPTY;
            live  <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head  <= result;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head <= result;
                    end else if (accept) begin
                        tail  <= result;
                        state <= ST_FULL;
                    end else if (drain) begin
                        head  <= '0;
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        head  <= tail;
                        tail  <= '0;
                        state <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                    head  <= '0;
                    tail  <= '0;
                end
            endcase
        end
    end

`ifdef LOGIC_PIPE_UNIT_CNT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            OP_CNT <= 16'h0000;
        end else if (drain && (OP_CNT != 16'hFFFF)) begin
            OP_CNT <= OP_CNT + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_logic_pipe_unit.sv
// tb/tb_logic_pipe_unit.sv - scoreboard bench for logic_pipe_unit
module tb_logic_pipe_unit;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [7:0] IN0 = 8'h00;
    logic [7:0] IN1 = 8'h00;
    logic [2:0] OP = 3'b000;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] OUT0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
`ifdef LOGIC_PIPE_UNIT_CNT_EN
    logic [15:0] OP_CNT;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    logic [7:0] sb_q[$];

    logic_pipe_unit #(.WIDTH(8)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .IN0(IN0),
        .IN1(IN1),
        .OP(OP),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .OUT0(OUT0),
        .OUT_VALID(OUT_VALID),
`ifdef LOGIC_PIPE_UNIT_CNT_EN
        .OUT_READY(OUT_READY),
        .OP_CNT(OP_CNT)
`else
        .OUT_READY(OUT_READY)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a | b);
            3'd3: return ~(a & b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Handshakes are resolved at the falling edge, where inputs and outputs are settled
    always @(negedge CLK) begin
        if (RSTn) begin
            if (OUT_VALID && OUT_READY) begin
                pop_cnt++;
                if (sb_q.size() == 0) check("sb_unexpected_out", {24'h0, OUT0}, 32'hFFFF_FFFF);
                else check("sb_data", {24'h0, OUT0}, {24'h0, sb_q.pop_front()});
            end
            if (!OUT_VALID) check("out0_zero_idle", {24'h0, OUT0}, 32'h0);
            if (IN_VALID && IN_READY) sb_q.push_back(model(IN0, IN1, OP));
        end
    end

    // Offers one beat starting just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        IN0 = a;
        IN1 = b;
        OP = op;
        IN_VALID = 1'b1;
        while (!acc && waited < 50) begin
            @(negedge CLK);
            acc = IN_READY;
            @(posedge CLK);
            #1;
            waited++;
        end
        if (!acc) check("send_timeout", 32'h0, 32'h1);
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        #1;
        check("rst_in_ready", {31'h0, IN_READY}, 32'h0);
        check("rst_out_valid", {31'h0, OUT_VALID}, 32'h0);
        check("rst_out0", {24'h0, OUT0}, 32'h0);
        sb_q.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", {31'h0, IN_READY}, 32'h0);
        @(posedge CLK);
        #1;
        check("rel_in_ready", {31'h0, IN_READY}, 32'h1);
        check("rel_out_valid", {31'h0, OUT_VALID}, 32'h0);
    endtask

    initial begin
        logic [7:0] op_tab[8];
        int w;
        int total;
        int pops_before;
        op_tab = '{8'h24, 8'hBD, 8'h42, 8'hDB, 8'h99, 8'h66, 8'h5A, 8'hA5};

        @(posedge CLK);
        do_reset();

        // Op table, each result one cycle after accept from empty
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'hA5, 8'h3C, 3'(i), w);
            check("optab_valid", {31'h0, OUT_VALID}, 32'h1);
            check($sformatf("optab_op%0d", i), {24'h0, OUT0}, {24'h0, op_tab[i]});
            @(posedge CLK);
            #1;
        end
        check("optab_drained", {31'h0, OUT_VALID}, 32'h0);

        // Backpressure: two stored, third held until downstream frees a slot
        OUT_READY = 1'b0;
        send(8'h00, 8'h00, 3'd2, w);
        send(8'h0F, 8'h00, 3'd2, w);
        fork
            send(8'hFF, 8'h00, 3'd2, w);
            begin
                for (int i = 0; i < 3; i++) begin
                    #2;
                    check("bp_in_ready", {31'h0, IN_READY}, 32'h0);
                    check("bp_out_valid", {31'h0, OUT_VALID}, 32'h1);
                    check("bp_out0", {24'h0, OUT0}, 32'hFF);
                    @(posedge CLK);
                    #1;
                end
                OUT_READY = 1'b1;
            end
        join
        check("bp_wait_cycles", w, 5);
        repeat (3) @(posedge CLK);
        #1;
        check("bp_queue_empty", sb_q.size(), 0);

        // ONE-state accept and drain together
        OUT_READY = 1'b0;
        send(8'h12, 8'h34, 3'd4, w);
        OUT_READY = 1'b1;
        send(8'hF0, 8'h3C, 3'd0, w);
        check("one_in_ready", {31'h0, IN_READY}, 32'h1);
        check("one_out_valid", {31'h0, OUT_VALID}, 32'h1);
        check("one_new_head", {24'h0, OUT0}, 32'h30);
        @(posedge CLK);
        #1;
        check("one_then_empty", {31'h0, OUT_VALID}, 32'h0);

        // Streaming at full rate
        pops_before = pop_cnt;
        total = 0;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), w);
            total += w;
        end
        @(posedge CLK);
        #1;
        check("stream_cycles", total, 100);
        check("stream_outputs", pop_cnt - pops_before, 100);
        check("stream_queue_empty", sb_q.size(), 0);

        // Reset with two entries stored
        OUT_READY = 1'b0;
        send(8'hAA, 8'h55, 3'd1, w);
        send(8'h0F, 8'hF0, 3'd4, w);
        check("pre_rst_full", {31'h0, IN_READY}, 32'h0);
        do_reset();
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("post_rst_no_stale", {31'h0, OUT_VALID}, 32'h0);

`ifdef LOGIC_PIPE_UNIT_CNT_EN
        check("cnt_reset", {16'h0, OP_CNT}, 32'h0);
        for (int i = 0; i < 65537; i++) send(8'(i), 8'h5A, 3'd4, w);
        @(posedge CLK);
        #1;
        check("cnt_saturated", {16'h0, OP_CNT}, 32'hFFFF);
        send(8'h01, 8'h02, 3'd1, w);
        @(posedge CLK);
        #1;
        check("cnt_holds", {16'h0, OP_CNT}, 32'hFFFF);
        RSTn = 1'b0;
        #1;
        check("cnt_cleared", {16'h0, OP_CNT}, 32'h0);
        sb_q.delete();
        @(negedge CLK);
        RSTn = 1'b1;
`endif

        check("final_queue_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
